// File: rtl/conv_window_buffer.sv
// Four rotating line buffers feeding a 3x3 window generator for the convolution stage.
// Build option: define CONV_WINDOW_ZERO_PAD_EN to read edge columns as zero instead of clamping.
module conv_window_buffer #(
  parameter int IMG_WIDTH = 512,
  parameter int PIX_W     = 8
) (
  input  logic                 axi_clk,
  input  logic                 axi_reset,
  input  logic [PIX_W-1:0]     i_pixel_data,
  input  logic                 i_pixel_data_valid,
  input  logic                 i_ready,
  output logic [9*PIX_W-1:0]   o_pixel_data,
  output logic                 o_pixel_data_valid,
  output logic                 o_intr
);

  localparam int COL_W  = $clog2(IMG_WIDTH);
  localparam int CE_W   = COL_W + 1;
  localparam int FILL_W = $clog2(4 * IMG_WIDTH) + 1;

  localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(4 * IMG_WIDTH);
  localparam logic [FILL_W-1:0] FILL_START = FILL_W'(3 * IMG_WIDTH);
  localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(IMG_WIDTH - 1);

  typedef enum logic {
    S_IDLE,
    S_READ
  } state_t;

  state_t state, state_next;

  logic [PIX_W-1:0] lb [4][IMG_WIDTH];

  logic [1:0]         wr_buf;
  logic [COL_W-1:0]   wr_col;
  logic [1:0]         rd_buf;
  logic [COL_W-1:0]   rd_col;
  logic [FILL_W-1:0]  fill;
  logic               full;
  logic               wr_en;
  logic               rd_en;
  logic [9*PIX_W-1:0] window;

  assign full  = (fill == FILL_FULL);
  assign wr_en = i_pixel_data_valid && !full;

  // NOTE: line storage has no reset; stale contents are never read because fill gates the reader.
  always_ff @(posedge axi_clk) begin
    if (wr_en) begin
      lb[wr_buf][wr_col] <= i_pixel_data;
    end
  end

  // NOTE: all state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      wr_buf <= '0;
      wr_col <= '0;
    end else if (wr_en) begin
      if (wr_col == LAST_COL) begin
        wr_col <= '0;
        wr_buf <= wr_buf + 2'd1;
      end else begin
        wr_col <= wr_col + COL_W'(1);
      end
    end
  end

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      fill <= '0;
    end else begin
      unique case ({wr_en, rd_en})
        2'b10:   fill <= fill + FILL_W'(1);
        2'b01:   fill <= fill - FILL_W'(1);
        default: fill <= fill;
      endcase
    end
  end

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_next = state;
    rd_en      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (fill >= FILL_START) begin
          state_next = S_READ;
        end
      end
      S_READ: begin
        rd_en = i_ready;
        if (i_ready && (rd_col == LAST_COL)) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      rd_buf <= '0;
      rd_col <= '0;
    end else if (rd_en) begin
      if (rd_col == LAST_COL) begin
        rd_col <= '0;
        rd_buf <= rd_buf + 2'd1;
      end else begin
        rd_col <= rd_col + COL_W'(1);
      end
    end
  end

  // Row 0 is the oldest line; the carry bit of col_ext marks columns past the right edge.
  always_comb begin : p_window
    logic [CE_W-1:0] col_ext;
    logic [1:0]      row_buf;
    window  = '0;
    col_ext = '0;
    row_buf = '0;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) begin
        row_buf = rd_buf + 2'(r);
        col_ext = {1'b0, rd_col} + CE_W'(k);
        if (!col_ext[COL_W]) begin
          window[(3*r+k)*PIX_W +: PIX_W] = lb[row_buf][col_ext[COL_W-1:0]];
        end else begin
`ifdef CONV_WINDOW_ZERO_PAD_EN
          window[(3*r+k)*PIX_W +: PIX_W] = '0;
`else
          window[(3*r+k)*PIX_W +: PIX_W] = lb[row_buf][LAST_COL];
`endif
        end
      end
    end
  end

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      o_pixel_data       <= '0;
      o_pixel_data_valid <= 1'b0;
      o_intr             <= 1'b0;
    end else begin
      o_pixel_data_valid <= rd_en;
      o_intr             <= rd_en && (rd_col == LAST_COL);
      if (rd_en) begin
        o_pixel_data <= window;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_buffer.sv
// Directed bench for conv_window_buffer: every window is compared against a line-tag model.
module tb_conv_window_buffer;

  localparam int W  = 512;
  localparam int PW = 8;

`ifdef CONV_WINDOW_ZERO_PAD_EN
  localparam logic [71:0] EXP_COL511 = 72'h000003_000002_000001;
`else
  localparam logic [71:0] EXP_COL511 = 72'h030303_020202_010101;
`endif

  logic          axi_clk = 1'b0;
  logic          axi_reset;
  logic [PW-1:0] i_pixel_data;
  logic          i_pixel_data_valid;
  logic          i_ready;
  logic [71:0]   o_pixel_data;
  logic          o_pixel_data_valid;
  logic          o_intr;

  always #5 axi_clk = ~axi_clk;

  conv_window_buffer #(.IMG_WIDTH(W), .PIX_W(PW)) dut (
    .axi_clk            (axi_clk),
    .axi_reset          (axi_reset),
    .i_pixel_data       (i_pixel_data),
    .i_pixel_data_valid (i_pixel_data_valid),
    .i_ready            (i_ready),
    .o_pixel_data       (o_pixel_data),
    .o_pixel_data_valid (o_pixel_data_valid),
    .o_intr             (o_intr)
  );

  int          errors = 0;
  int          checks = 0;
  int          lines[$];
  int          mon_base;
  int          mon_col;
  int          win_count = 0;
  int          intr_count = 0;
  logic [71:0] last_win;
  logic [71:0] line_end_win = '0;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Tags below 256 are constant lines; larger tags give a column-dependent pattern.
  function automatic logic [7:0] pix_of(input int tag, input int col);
    if (tag < 256) return 8'(tag);
    return 8'((tag * 7 + col * 3) % 256);
  endfunction

  function automatic logic [7:0] exp_pix(input int tag, input int col);
    if (col < W) return pix_of(tag, col);
`ifdef CONV_WINDOW_ZERO_PAD_EN
    return 8'h00;
`else
    return pix_of(tag, W - 1);
`endif
  endfunction

  function automatic logic [71:0] exp_window(input int base, input int col);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++)
        w[(3*r+k)*8 +: 8] = exp_pix(lines[base+r], col + k);
    return w;
  endfunction

  task automatic sample();
    if (o_pixel_data_valid) begin
      if (lines.size() < mon_base + 3)
        check("win_early", 72'(o_pixel_data_valid), 72'd0);
      else
        check($sformatf("win l%0d c%0d", mon_base, mon_col), o_pixel_data,
              exp_window(mon_base, mon_col));
      check("intr_pos", 72'(o_intr), 72'(mon_col == W - 1));
      last_win = o_pixel_data;
      if (mon_col == W - 1) line_end_win = o_pixel_data;
      win_count++;
      if (o_intr) intr_count++;
      if (mon_col == W - 1) begin
        mon_col = 0;
        mon_base++;
      end else begin
        mon_col++;
      end
    end else begin
      check("hold", o_pixel_data, last_win);
      check("intr_idle", 72'(o_intr), 72'd0);
    end
  endtask

  task automatic tick();
    @(posedge axi_clk);
    @(negedge axi_clk);
    sample();
  endtask

  task automatic model_reset();
    mon_base = lines.size();
    mon_col  = 0;
    last_win = '0;
  endtask

  task automatic write_pixels(input int tag, input int c0, input int c1);
    for (int c = c0; c <= c1; c++) begin
      i_pixel_data       = pix_of(tag, c);
      i_pixel_data_valid = 1'b1;
      tick();
    end
    i_pixel_data_valid = 1'b0;
  endtask

  task automatic write_line(input int tag);
    lines.push_back(tag);
    write_pixels(tag, 0, W - 1);
  endtask

  task automatic wait_intr(input int target, input string tag);
    int n = 0;
    while (intr_count < target && n < 3000) begin
      tick();
      n++;
    end
    check(tag, 72'(intr_count), 72'(target));
  endtask

  task automatic wait_col(input int col, input string tag);
    int n = 0;
    while (mon_col != col && n < 3000) begin
      tick();
      n++;
    end
    check(tag, 72'(mon_col), 72'(col));
  endtask

  initial begin
    int n;
    int w0;
    int ic0;

    axi_reset          = 1'b1;
    i_pixel_data       = '0;
    i_pixel_data_valid = 1'b0;
    i_ready            = 1'b1;
    model_reset();
    repeat (3) tick();
    check("rst_data", o_pixel_data, 72'd0);
    check("rst_valid", 72'(o_pixel_data_valid), 72'd0);
    check("rst_intr", 72'(o_intr), 72'd0);
    axi_reset = 1'b0;
    tick();

    // First line: constant lines 1,2,3; first window two cycles after the last write.
    write_line(1);
    write_line(2);
    write_line(3);
    check("no_early_win", 72'(win_count), 72'd0);
    n = 0;
    while (win_count == 0 && n < 10) begin
      tick();
      n++;
    end
    check("first_lat", 72'(n), 72'd2);
    check("first_win", o_pixel_data, 72'h030303_020202_010101);
    wait_intr(1, "line1_intr");
    check("line1_wins", 72'(win_count), 72'd512);
    check("col511", line_end_win, EXP_COL511);
    repeat (5) tick();
    check("idle_after", 72'(win_count), 72'd512);

    // Backpressure: stall ten cycles at column 100 of the (2,3,300) window line.
    write_line(300);
    wait_col(100, "bp_reach");
    i_ready = 1'b0;
    w0 = win_count;
    repeat (10) tick();
    check("bp_gap", 72'(win_count), 72'(w0));
    i_ready = 1'b1;
    wait_intr(2, "bp_intr");
    check("bp_wins", 72'(win_count), 72'd1024);

    // Asynchronous reset in the middle of a readout.
    write_line(301);
    wait_col(50, "rst_reach");
    check("rst_pre_valid", 72'(o_pixel_data_valid), 72'd1);
    #2 axi_reset = 1'b1;
    #1;
    check("arst_data", o_pixel_data, 72'd0);
    check("arst_valid", 72'(o_pixel_data_valid), 72'd0);
    check("arst_intr", 72'(o_intr), 72'd0);
    check("arst_fill", 72'(dut.fill), 72'd0);
    model_reset();
    repeat (2) tick();
    axi_reset = 1'b0;
    w0  = win_count;
    ic0 = intr_count;
    lines.push_back(1);
    lines.push_back(2);
    lines.push_back(3);
    write_pixels(1, 0, W - 1);
    write_pixels(2, 0, W - 1);
    write_pixels(3, 0, W - 2);
    repeat (5) tick();
    check("rst_1535_noval", 72'(win_count), 72'(w0));
    check("rst_1535_fill", 72'(dut.fill), 72'd1535);

    // Wrap-around: lines 1..6, one refill per interrupt.
    write_pixels(3, W - 1, W - 1);
    write_line(4);
    wait_intr(ic0 + 1, "wrap_intr1");
    write_line(5);
    wait_intr(ic0 + 2, "wrap_intr2");
    write_line(6);
    wait_intr(ic0 + 3, "wrap_intr3");
    check("wrap_rdbuf3", 72'(dut.rd_buf), 72'd3);
    wait_intr(ic0 + 4, "wrap_intr4");
    check("wrap_rdbuf0", 72'(dut.rd_buf), 72'd0);
    check("wrap_wrbuf", 72'(dut.wr_buf), 72'd2);
    check("wrap_wins", 72'(win_count - w0), 72'd2048);

    // Simultaneous write and read for a whole line keeps fill constant.
    write_line(302);
    check("sim_fill_pre", 72'(dut.fill), 72'd1536);
    lines.push_back(303);
    for (int c = 0; c < W; c++) begin
      i_pixel_data       = pix_of(303, c);
      i_pixel_data_valid = 1'b1;
      tick();
      check($sformatf("sim_fill c%0d", c), 72'(dut.fill), 72'd1537);
    end
    i_pixel_data_valid = 1'b0;
    wait_intr(ic0 + 5, "sim_intr5");
    wait_intr(ic0 + 6, "sim_intr6");

    // Overflow: a write while full is dropped without side effects.
    axi_reset = 1'b1;
    model_reset();
    repeat (2) tick();
    axi_reset = 1'b0;
    i_ready   = 1'b0;
    ic0       = intr_count;
    write_line(304);
    write_line(305);
    write_line(306);
    write_line(307);
    check("ovf_fill_full", 72'(dut.fill), 72'd2048);
    i_pixel_data       = 8'hFF;
    i_pixel_data_valid = 1'b1;
    tick();
    i_pixel_data_valid = 1'b0;
    check("ovf_fill_hold", 72'(dut.fill), 72'd2048);
    check("ovf_wrbuf", 72'(dut.wr_buf), 72'd0);
    check("ovf_wrcol", 72'(dut.wr_col), 72'd0);
    repeat (3) tick();
    i_ready = 1'b1;
    wait_intr(ic0 + 1, "ovf_intr1");
    wait_intr(ic0 + 2, "ovf_intr2");
    check("ovf_fill_end", 72'(dut.fill), 72'd1024);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
